// File: rtl/aes_pkg.sv
// Shared AES data-path definitions: GF(2^8) helpers built from xtime, state widths
// and the iterative MixColumns FSM encoding.
package aes_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column (byte 0 = MS byte).
module mix_column_word
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  input  logic             inv_i,
  output logic [COL_W-1:0] col_o
);

  logic [7:0] b0, b1, b2, b3;

  assign {b0, b1, b2, b3} = col_i;

  always_comb begin
    if (inv_i) begin
      col_o = {gmule(b0) ^ gmulb(b1) ^ gmuld(b2) ^ gmul9(b3),
               gmul9(b0) ^ gmule(b1) ^ gmulb(b2) ^ gmuld(b3),
               gmuld(b0) ^ gmul9(b1) ^ gmule(b2) ^ gmulb(b3),
               gmulb(b0) ^ gmuld(b1) ^ gmul9(b2) ^ gmule(b3)};
    end else begin
      col_o = {gmul2(b0) ^ gmul3(b1) ^ b2 ^ b3,
               b0 ^ gmul2(b1) ^ gmul3(b2) ^ b3,
               b0 ^ b1 ^ gmul2(b2) ^ gmul3(b3),
               gmul3(b0) ^ b1 ^ b2 ^ gmul2(b3)};
    end
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns/InvMixColumns: COLS_PER_CYCLE columns per clock, updated in
// place in the work register, with valid/ready handshakes on both sides.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_in_ready,
  input  logic [STATE_W-1:0] i_data,
  input  logic               i_inverse,
  output logic               o_valid,
  input  logic               i_out_ready,
  output logic [STATE_W-1:0] o_data,
  output logic               o_busy
);

  localparam int unsigned N_STEPS   = 4 / COLS_PER_CYCLE;
  localparam logic [1:0]  LAST_STEP = 2'(N_STEPS - 1);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e                    state_q, state_d;
  logic [3:0][COL_W-1:0]     work_q, work_d;
  logic                      mode_q, mode_d;
  logic [1:0]                cnt_q, cnt_d;
  logic                      in_ready;
  logic [1:0]                lane_sel [COLS_PER_CYCLE];
  logic [COL_W-1:0]          lane_out [COLS_PER_CYCLE];

  // Column c lives in packed element 3-c so that work_q maps directly onto i_data/o_data.
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
    assign lane_sel[j] = 2'(3 - (COLS_PER_CYCLE * 32'(cnt_q) + j));

    mix_column_word u_word (
      .col_i (work_q[lane_sel[j]]),
      .inv_i (mode_q),
      .col_o (lane_out[j])
    );
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (i_valid) begin
          work_d  = i_data;
          mode_d  = i_inverse;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
          work_d[lane_sel[j]] = lane_out[j];
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_STEP) state_d = ST_DONE;
      end
      ST_DONE: begin
        in_ready = i_out_ready;
        if (i_out_ready) begin
          if (i_valid) begin
            work_d  = i_data;
            mode_d  = i_inverse;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_in_ready = in_ready;
  assign o_valid    = (state_q == ST_DONE);
  assign o_busy     = (state_q == ST_BUSY);
  assign o_data     = work_q;

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
Parametrised successor to the single-cycle MixColumns stage, in AES-128 data-path style. Performs forward MixColumns (encrypt) or InvMixColumns (decrypt), selected per block, on a 128-bit state. Processes COLS_PER_CYCLE columns per clock, trading area for latency. Uses valid/ready handshakes on input and output, so it can sit between ShiftRows and AddRoundKey in an iterative round engine with back-pressure.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2 and 4; any other value is an elaboration error.
N_STEPS, 4/COLS_PER_CYCLE, derived localparam, not overridable; number of BUSY cycles.

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  input block valid
o_in_ready  out  1  block can accept input this cycle
i_data  in  128  input state; column c = bits [127-32c : 96-32c]; byte 0 of a column is its MS byte
i_inverse  in  1  0 = MixColumns, 1 = InvMixColumns; sampled with i_data
o_valid  out  1  result valid
i_out_ready  in  1  downstream accepts result
o_data  out  128  result, same layout as i_data
o_busy  out  1  high in BUSY state

Behaviour:
- Clock and reset: one clock (i_clock); reset is asynchronous and active-high (i_reset).
- Reset values: state=IDLE, o_valid=0, o_busy=0, o_data=0, column counter=0, mode register=0. Reset asserted mid-operation aborts the block immediately. No partial result is emitted.
- FSM states: IDLE, BUSY, DONE.
- IDLE: o_in_ready=1. On i_valid, capture i_data into the work register and i_inverse into the mode register, clear the counter, then go to BUSY.
- BUSY: o_in_ready=0, o_busy=1. Each cycle replaces columns [k*C .. k*C+C-1] of the work register in place, where k is the counter and C is COLS_PER_CYCLE. The counter increments. When k = N_STEPS-1 the FSM goes to DONE on that edge.
- DONE: o_valid=1. o_data equals the work register and is held stable until the handshake.
  - o_in_ready = i_out_ready (combinational).
  - On i_out_ready with i_valid=0: go to IDLE.
  - On i_out_ready with i_valid=1: capture the new block and go directly to BUSY (back-to-back, no bubble).
  - On i_out_ready=0: stay in DONE; inputs are ignored.
- Latency: o_valid rises N_STEPS cycles after the accepting edge (4, 2 or 1). Throughput is one block per N_STEPS+1 cycles when downstream is always ready.
- Forward column transform, GF(2^8) with polynomial 0x11b: r0=2b0^3b1^b2^b3; r1=b0^2b1^3b2^b3; r2=b0^b1^2b2^3b3; r3=3b0^b1^b2^2b3.
- Inverse column transform: coefficients 0e, 0b, 0d, 09 in the same circulant order.
- xtime(x) = {x[6:0],0} ^ (0x1b & {8{x[7]}}). Higher multiples are built from xtime and XOR only; no lookup tables.
- i_inverse changing during BUSY or DONE has no effect.
- o_data between blocks: holds the last result and does not clear on the handshake.

Decomposition:
- Package aes_pkg: xtime function; gmul2/3/9/b/d/e functions; STATE_W=128 and COL_W=32 constants; FSM state enum.
- Sub-module mix_column_word: purely combinational, with ports 32-bit in, mode, and 32-bit out. It is instantiated COLS_PER_CYCLE times, and a mux selects columns by the counter.

Test Plan:
- Forward, C=1: column db135345 (all four columns) -> every column 8e4da1bc. o_valid rises exactly 4 cycles after accept.
- Forward FIPS-197 round-1 columns d4bf5d30 e0b452ae b84111f1 1e2798e5 -> 046681e5 e0cb199a 48f8d37a 2806264c. Run for C=1, 2 and 4. Latency must be 4, 2 and 1 respectively.
- Inverse: 8e4da1bc / 9fdc589d / 01010101 / d5d5d7d6 -> db135345 / f20a225c / 01010101 / d4d4d4d5. A forward-then-inverse round trip on random data returns the original.
- Back-pressure: hold i_out_ready=0 for 10 cycles in DONE. o_data stays stable, o_in_ready=0, and a pulsed i_valid is not accepted. Releasing i_out_ready together with i_valid starts the next block with no idle cycle.
- Reset mid-BUSY (C=1, counter=2): o_valid, o_busy and o_data are 0 asynchronously. After release, a fresh block completes correctly.
- Streaming 100 random blocks with random i_out_ready: output order and values match the reference model, with no drops or duplicates.
